// File: rtl/toggle_pkg.sv
// Shared defaults and the occupancy view for the toggle-event receiver.
// No logic of its own; latency and backpressure are defined by the users.
// The occupancy helper maps a pending count onto EMPTY/ACTIVE/FULL.
package toggle_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 4;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } occ_e;

    function automatic occ_e occ_of(input int cnt, input int pmax);
        if (cnt == 0)
            return EMPTY;
        else if (cnt >= pmax)
            return FULL;
        return ACTIVE;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for one asynchronous level.
// Latency: STAGES clk edges from input change to output change.
// No backpressure: samples every cycle.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else
            q <= {q[STAGES-2:0], din};
    end

    assign dout = q[STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Turns each level change of a remote toggle into a local event and a pending count.
// Latency: evt_pulse and the count increment appear after edge SYNC_STAGES+1.
// Backpressure: evt_valid/evt_ready drain the count; saturation drops events into sticky ovf.
module toggle_event_rx
    import toggle_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgl_in,
    output logic             evt_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] pending,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] PMAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic sync_last;
    logic prev;
    logic det;
    logic pop;
    logic lost;
    occ_e occ;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (tgl_in),
        .dout (sync_last)
    );

    assign det       = sync_last ^ prev;
    assign evt_valid = (pending != '0);
    assign pop       = evt_valid && evt_ready;
    // A simultaneous pop frees the slot, so only an unmatched detect at PMAX is lost.
    assign lost      = det && !pop && (pending == PMAX);
    assign occ       = occ_of(int'(pending), int'(PMAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev      <= 1'b0;
            evt_pulse <= 1'b0;
            pending   <= '0;
            ovf       <= 1'b0;
        end else begin
            prev      <= sync_last;
            evt_pulse <= det;
            if (det && !pop && (pending != PMAX))
                pending <= pending + ONE;
            else if (pop && !det)
                pending <= pending - ONE;
            if (lost)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    a_full_loss_sets_ovf: assert property (
        @(posedge clk) disable iff (rst) (occ == FULL && det && !pop) |=> ovf
    );

endmodule
